// File: rtl/kogge_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder/subtractor.
//   pg_t       : per-bit (propagate, generate) pair carried through the prefix tree
//   clog2      : ceiling log2, used to size the prefix tree
//   num_stages : number of registered prefix stages for a width / levels-per-stage pair
//   LEVELS, S  : prefix levels and prefix stages for the default configuration
package kogge_pkg;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int num_stages(input int width, input int lps);
    return (clog2(width) + lps - 1) / lps;
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int DEF_LPS   = 2;
  localparam int LEVELS    = clog2(DEF_WIDTH);
  localparam int S         = num_stages(DEF_WIDTH, DEF_LPS);

endpackage

// File: rtl/kogge_black_cell.sv
// Kogge-Stone black cell: merges a higher group (i_hi) with the adjacent
// lower group (i_lo) into one wider group (o_pg).
//   i_hi : (P, G) of the more significant group
//   i_lo : (P, G) of the less significant group
//   o_pg : combined (P, G)
module kogge_black_cell
  import kogge_pkg::*;
(
  input  pg_t i_hi,
  input  pg_t i_lo,
  output pg_t o_pg
);

  assign o_pg.g = i_hi.g | (i_hi.p & i_lo.g);
  assign o_pg.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined, parametrised Kogge-Stone adder/subtractor with a valid/ready
// stream interface.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand beat handshake
//   a, b, cin, sub       : operands; sub=1 gives a-b, sub=0 gives a+b+cin
//   out_valid / out_ready: result beat handshake
//   sum, cout, ovf       : registered result, carry out, signed overflow
//
// The prefix tree runs over WIDTH+1 positions: position 0 carries the
// carry-in (p=0, g=c0) and position i+1 carries bit i. After the tree,
// G at position i is the carry into bit i.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; valid, once raised, is held with stable data until that edge. Every
// stage (prefix stages 1..S, then the output register) loads when it is
// empty or when the stage after it loads, so empty stages fill even while
// the output is stalled. in_ready is the load condition of stage 1 and
// therefore depends combinationally on out_ready.
module kogge_stone_pipe
  import kogge_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LPS   = DEF_LPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NLEVELS = clog2(WIDTH);
  localparam int NSTAGES = num_stages(WIDTH, LPS);
  // Level slots including pass-through levels that pad the last stage.
  localparam int NLV     = NSTAGES * LPS;

  logic [WIDTH-1:0]   w_bb;
  logic [WIDTH-1:0]   w_p0;
  logic [WIDTH-1:0]   w_g0;
  logic               w_c0;

  // w_lv[n]  : prefix state after level n (n=0 is the bit-level p/g).
  // w_src[n] : input of level n, either the previous level or a stage register.
  pg_t                w_lv  [0:NLV][0:WIDTH];
  pg_t                w_src [1:NLV][0:WIDTH];

  pg_t                r_pg  [1:NSTAGES][0:WIDTH];
  logic [WIDTH-1:0]   r_p   [1:NSTAGES];
  logic [NSTAGES:1]   r_v;
  logic [NSTAGES+1:1] w_adv;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;

  // Bit-level propagate/generate with subtract folded into operand B.
  assign w_bb = sub ? ~b : b;
  assign w_c0 = sub | cin;
  assign w_p0 = a ^ w_bb;
  assign w_g0 = a & w_bb;

  assign w_lv[0][0] = '{p: 1'b0, g: w_c0};
  for (genvar j = 0; j < WIDTH; j++) begin : g_lv0
    assign w_lv[0][j+1] = '{p: w_p0[j], g: w_g0[j]};
  end

  for (genvar n = 1; n <= NLV; n++) begin : g_level
    localparam int D = 1 << (n - 1);
    for (genvar j = 0; j <= WIDTH; j++) begin : g_bit
      // The first level of every stage after the first reads the register
      // that closed the previous stage.
      if (n > 1 && ((n - 1) % LPS) == 0) begin : g_from_reg
        assign w_src[n][j] = r_pg[(n-1)/LPS][j];
      end else begin : g_from_comb
        assign w_src[n][j] = w_lv[n-1][j];
      end
      if (n <= NLEVELS && j >= D) begin : g_cell
        kogge_black_cell u_cell (
          .i_hi (w_src[n][j]),
          .i_lo (w_src[n][j-D]),
          .o_pg (w_lv[n][j])
        );
      end else begin : g_pass
        assign w_lv[n][j] = w_src[n][j];
      end
    end
  end

  // Load conditions, evaluated from the output back towards the input.
  always_comb begin
    w_adv = '0;
    w_adv[NSTAGES+1] = ~r_out_valid | out_ready;
    for (int s = NSTAGES; s >= 1; s--) begin
      w_adv[s] = ~r_v[s] | w_adv[s+1];
    end
  end

  // Final carries. After LEVELS levels the top position spans bits
  // [WIDTH-1:0] but not the carry-in slot, so one last merge with
  // position 0 completes the carry out of the MSB.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = r_p[NSTAGES][i] ^ r_pg[NSTAGES][i].g;
    end
    w_cout = r_pg[NSTAGES][WIDTH].g |
             (r_pg[NSTAGES][WIDTH].p & r_pg[NSTAGES][0].g);
    w_ovf  = w_cout ^ r_pg[NSTAGES][WIDTH-1].g;
  end

  // Valid bits and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_adv[1]) r_v[1] <= in_valid;
      for (int s = 2; s <= NSTAGES; s++) begin
        if (w_adv[s]) r_v[s] <= r_v[s-1];
      end
      if (w_adv[NSTAGES+1]) begin
        r_out_valid <= r_v[NSTAGES];
        if (r_v[NSTAGES]) begin
          r_sum  <= w_sum;
          r_cout <= w_cout;
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  // Datapath registers load only with a valid beat; no reset needed.
  always_ff @(posedge clk) begin
    if (w_adv[1] && in_valid) begin
      r_p[1] <= w_p0;
      for (int j = 0; j <= WIDTH; j++) r_pg[1][j] <= w_lv[LPS][j];
    end
    for (int s = 2; s <= NSTAGES; s++) begin
      if (w_adv[s] && r_v[s-1]) begin
        r_p[s] <= r_p[s-1];
        for (int j = 0; j <= WIDTH; j++) r_pg[s][j] <= w_lv[s*LPS][j];
      end
    end
  end

  assign in_ready  = w_adv[1];
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_kogge_stone_pipe.sv
`timescale 1ns/1ps
module tb_kogge_stone_pipe;

  // Expected latencies: W16/LPS2 -> 4 levels, 2 stages; W4/LPS1 -> 2 levels,
  // 2 stages; W64/LPS3 -> 6 levels, 2 stages. Each adds the output register.
  localparam int LAT16 = 3;
  localparam int LAT4  = 3;
  localparam int LAT64 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic m_in_valid = 0, m_in_ready, m_cin = 0, m_sub = 0;
  logic m_out_valid, m_out_ready = 1, m_cout, m_ovf;
  logic [15:0] m_a = 0, m_b = 0, m_sum;

  logic d4_in_valid = 0, d4_in_ready, d4_cin = 0, d4_sub = 0;
  logic d4_out_valid, d4_out_ready = 1, d4_cout, d4_ovf;
  logic [3:0] d4_a = 0, d4_b = 0, d4_sum;

  logic d64_in_valid = 0, d64_in_ready, d64_cin = 0, d64_sub = 0;
  logic d64_out_valid, d64_out_ready = 1, d64_cout, d64_ovf;
  logic [63:0] d64_a = 0, d64_b = 0, d64_sum;

  kogge_stone_pipe #(.WIDTH(16), .LPS(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .sum(m_sum), .cout(m_cout), .ovf(m_ovf));

  kogge_stone_pipe #(.WIDTH(4), .LPS(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .cin(d4_cin), .sub(d4_sub),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready),
    .sum(d4_sum), .cout(d4_cout), .ovf(d4_ovf));

  kogge_stone_pipe #(.WIDTH(64), .LPS(3)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(d64_in_valid), .in_ready(d64_in_ready),
    .a(d64_a), .b(d64_b), .cin(d64_cin), .sub(d64_sub),
    .out_valid(d64_out_valid), .out_ready(d64_out_ready),
    .sum(d64_sum), .cout(d64_cout), .ovf(d64_ovf));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  // Packed as {ovf, cout, sum zero-extended to 64 bits}.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic ci, input logic sb);
    logic [64:0] mask, t;
    logic [63:0] bb;
    logic        c0, co, ov;
    mask = (65'd1 << w) - 65'd1;
    bb   = sb ? (~b & mask[63:0]) : b;
    c0   = sb ? 1'b1 : ci;
    t    = {1'b0, a} + {1'b0, bb} + {64'd0, c0};
    co   = t[w];
    ov   = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
    return {ov, co, t[63:0] & mask[63:0]};
  endfunction

  // ---------------- scoreboards ----------------
  logic [65:0] exp_q[$];
  logic [65:0] exp4_q[$];
  logic [65:0] exp64_q[$];
  int acc_q[$];
  int acc4_q[$];
  int acc64_q[$];

  int m_acc_cnt = 0, m_out_cnt = 0;
  int tp_first = -1, tp_last = -1;
  logic lat_en = 1'b1;
  logic [65:0] m_last = '0;

  always @(negedge clk) begin : mon_main
    logic [65:0] obs, e;
    int t0;
    if (!rst) begin
      if (m_in_valid && m_in_ready) begin
        exp_q.push_back(ref_model(16, 64'(m_a), 64'(m_b), m_cin, m_sub));
        acc_q.push_back(cyc);
        m_acc_cnt++;
      end
      if (m_out_valid && m_out_ready) begin
        obs = {m_ovf, m_cout, 48'd0, m_sum};
        m_last = obs;
        m_out_cnt++;
        if (tp_first < 0) tp_first = cyc;
        tp_last = cyc;
        check("m_beat_expected", 66'(exp_q.size() != 0), 66'd1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          t0 = acc_q.pop_front();
          check("m_result", obs, e);
          if (lat_en) check("m_latency", 66'(cyc - t0), 66'(LAT16));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_4
    logic [65:0] obs;
    int t0;
    if (!rst) begin
      if (d4_in_valid && d4_in_ready) begin
        exp4_q.push_back(ref_model(4, 64'(d4_a), 64'(d4_b), d4_cin, d4_sub));
        acc4_q.push_back(cyc);
      end
      if (d4_out_valid && d4_out_ready) begin
        obs = {d4_ovf, d4_cout, 60'd0, d4_sum};
        check("w4_beat_expected", 66'(exp4_q.size() != 0), 66'd1);
        if (exp4_q.size() != 0) begin
          t0 = acc4_q.pop_front();
          check("w4_result", obs, exp4_q.pop_front());
          check("w4_latency", 66'(cyc - t0), 66'(LAT4));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_64
    logic [65:0] obs;
    int t0;
    if (!rst) begin
      if (d64_in_valid && d64_in_ready) begin
        exp64_q.push_back(ref_model(64, d64_a, d64_b, d64_cin, d64_sub));
        acc64_q.push_back(cyc);
      end
      if (d64_out_valid && d64_out_ready) begin
        obs = {d64_ovf, d64_cout, d64_sum};
        check("w64_beat_expected", 66'(exp64_q.size() != 0), 66'd1);
        if (exp64_q.size() != 0) begin
          t0 = acc64_q.pop_front();
          check("w64_result", obs, exp64_q.pop_front());
          check("w64_latency", 66'(cyc - t0), 66'(LAT64));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end just after a rising edge.
  task automatic send_m(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
    int g = 0;
    m_a = a; m_b = b; m_cin = ci; m_sub = sb; m_in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("m_send_timeout", 66'(g), 66'd0);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
  endtask

  task automatic send_4(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb);
    int g = 0;
    d4_a = a; d4_b = b; d4_cin = ci; d4_sub = sb; d4_in_valid = 1'b1;
    @(negedge clk);
    while (!d4_in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("w4_send_timeout", 66'(g), 66'd0);
    @(posedge clk); #1;
    d4_in_valid = 1'b0;
  endtask

  task automatic send_64(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
    int g = 0;
    d64_a = a; d64_b = b; d64_cin = ci; d64_sub = sb; d64_in_valid = 1'b1;
    @(negedge clk);
    while (!d64_in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) check("w64_send_timeout", 66'(g), 66'd0);
    @(posedge clk); #1;
    d64_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while ((exp_q.size() + exp4_q.size() + exp64_q.size()) != 0 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, 66'(exp_q.size() + exp4_q.size() + exp64_q.size()), 66'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : main
    int c0;
    logic took;
    logic have_hold;
    logic [65:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {m_out_valid, m_cout, m_ovf, m_sum}, 66'd0);
    check("reset_in_ready", 66'(m_in_ready), 66'd1);
    @(posedge clk); #1;

    // T1: carry ripples across the full width
    c0 = m_out_cnt;
    send_m(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (8) @(posedge clk); #1;
    check("t1_valid_cycles", 66'(m_out_cnt - c0), 66'd1);
    check("t1_result", m_last, {1'b0, 1'b1, 64'h0});

    // T2: subtract with and without signed overflow
    send_m(16'h8000, 16'h0001, 1'b0, 1'b1);
    repeat (6) @(posedge clk); #1;
    check("t2_sub_ovf", m_last, {1'b1, 1'b1, 64'h7FFF});
    send_m(16'h0003, 16'h0005, 1'b0, 1'b1);
    repeat (6) @(posedge clk); #1;
    check("t2_sub_neg", m_last, {1'b0, 1'b0, 64'hFFFE});

    // T3: back-to-back random beats at full throughput
    tp_first = -1;
    c0 = m_out_cnt;
    for (int i = 0; i < 100; i++) begin
      send_m(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain("t3_drain");
    check("t3_count", 66'(m_out_cnt - c0), 66'd100);
    check("t3_throughput", 66'(tp_last - tp_first), 66'd99);

    // T4: output stalled for 10 cycles while the producer keeps offering beats
    lat_en = 1'b0;
    m_out_ready = 1'b0;
    c0 = m_acc_cnt;
    have_hold = 1'b0;
    held = '0;
    m_a = 16'($urandom_range(0, 65535)); m_b = 16'($urandom_range(0, 65535));
    m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
    m_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = m_in_ready;
      if (m_out_valid && !have_hold) begin
        held = {m_ovf, m_cout, 48'd0, m_sum};
        have_hold = 1'b1;
      end
      @(posedge clk); #1;
      if (took) begin
        m_a = 16'($urandom_range(0, 65535)); m_b = 16'($urandom_range(0, 65535));
        m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    check("t4_accepted", 66'(m_acc_cnt - c0), 66'(LAT16));
    check("t4_in_ready_low", 66'(m_in_ready), 66'd0);
    check("t4_out_valid_held", 66'(m_out_valid), 66'd1);
    check("t4_out_stable", {m_ovf, m_cout, 48'd0, m_sum}, held);
    @(posedge clk); #1;
    c0 = m_out_cnt;
    m_out_ready = 1'b1;
    send_m(m_a, m_b, m_cin, m_sub);
    wait_drain("t4_drain");
    repeat (4) @(posedge clk); #1;
    check("t4_drained_beats", 66'(m_out_cnt - c0), 66'(LAT16 + 1));

    // T5: reset while two beats are in flight
    send_m(16'h1234, 16'h4321, 1'b0, 1'b0);
    send_m(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", 66'(m_out_valid), 66'd0);
    check("t5_sum", 66'(m_sum), 66'd0);
    check("t5_in_ready", 66'(m_in_ready), 66'd1);
    c0 = m_out_cnt;
    repeat (10) @(posedge clk); #1;
    check("t5_no_stale", 66'(m_out_cnt - c0), 66'd0);

    // T6a: exhaustive 4-bit sweep, add and subtract (cin must be ignored on sub)
    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            send_4(4'(a), 4'(b), 1'(ci), 1'(sb));

    // T6b: 64-bit random, including operands near the wrap boundary
    send_64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    send_64(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1);
    send_64(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      send_64({$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain("t6_drain");
    repeat (5) @(posedge clk); #1;
    check("final_queues_empty", 66'(exp_q.size() + exp4_q.size() + exp64_q.size()), 66'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
